i2c_controller: RTL and testbench
=================================

# i2c_controller

Single-byte I2C controller (initiator) that drives SCL/SDA toward the on-chip I2C target and its bus peers. Accepts one command per handshake: write one byte to a 7-bit address, or read one byte from it. Generates START, address+R/W, ACK handling, data, and STOP with fixed quarter-period timing. Used by bench harnesses and by the FPGA bring-up top to exercise the target over its SCL_in/SDA_in pins.

## Interface

Parameters:
- QTR, default 25: clock cycles per SCL quarter-period; minimum 4. SCL period is 4*QTR cycles.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high when idle and able to accept
- cmd_addr  in  7  target address
- cmd_rw  in  1  0 = write, 1 = read
- cmd_wdata  in  8  byte to write; ignored for reads
- rdata  out  8  byte read; held until the next read completes
- done  out  1  one-cycle pulse at transaction end
- ack_err  out  1  valid with done; 1 = NACK on address or write data
- busy  out  1  transaction in progress
- scl_out  out  1  SCL level (1 = released/high)
- sda_out  out  1  SDA level (1 = released/high)
- sda_in  in  1  sampled SDA line (asynchronous; synchronized internally)

## Operation

- Accept: cmd_valid && cmd_ready on a clock edge latches addr, rw, wdata; cmd_ready falls and busy rises next cycle. cmd_valid while busy is ignored.
- States: IDLE -> START -> ADDR (8 bits: addr[6:0] MSB first, then rw) -> ADDR_ACK -> DATA (8 bits) -> DATA_ACK -> STOP -> IDLE.
- Each bit is four quarters q0..q3. q0,q1: SCL low; SDA changes only at the start of q0. q2,q3: SCL high.
- Sampling: sda_in passes a 2-flop synchronizer; SDA is sampled on the last cycle of q3.
- START: q0,q1 SCL=1 SDA=1; q2,q3 SCL=1 SDA=0.
- STOP: q0..q2 SDA=0 (SCL low in q0,q1, high in q2); q3 SCL=1 SDA=1.
- ADDR_ACK: SDA released. Sampled 1 means NACK: skip DATA/DATA_ACK, go to STOP, ack_err=1.
- Write DATA: drive wdata MSB first. DATA_ACK: release SDA; sampled 1 sets ack_err.
- Read DATA: release SDA and shift sampled bits MSB first. DATA_ACK: controller drives NACK (SDA=1). rdata updates when STOP begins.
- Completion: at the end of STOP q3, done pulses for one cycle, ack_err is valid in that cycle, then state returns to IDLE with cmd_ready=1.
- ack_err holds its value until the next accepted command clears it.

## Timing

- Reset values: scl_out=1, sda_out=1, cmd_ready=1, busy=0, done=0, ack_err=0, rdata=8'h00, state IDLE, quarter counter 0.
- Acceptance edge is cycle 0. START q0 begins in cycle 1.
- Full transaction: START 4 + ADDR 32 + ACK 4 + DATA 32 + ACK 4 + STOP 4 = 80 quarters. done is high in cycle 80*QTR+1.
- Address NACK: 4 + 36 + 4 = 44 quarters. done is high in cycle 44*QTR+1.
- cmd_ready is high again in the cycle after done, so the earliest back-to-back accept is that cycle.
- Bus idle time between back-to-back transactions is at least 1 cycle after STOP q3.
- Reset mid-operation: all outputs go to reset values immediately (asynchronous). No STOP is generated.
- Counter widths: quarter counter is $clog2(QTR) bits and wraps at QTR-1. Bit counter is 3 bits and counts 7 down to 0.

## Structure

- Shared package i2c_pkg holds:
  - state enum i2c_state_t (IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP);
  - quarter typedef qtr_t (Q0..Q3);
  - localparam I2C_RW_WRITE=0, I2C_RW_READ=1.
- One sub-module, i2c_qtr_tick: QTR-cycle counter producing a tick and the 2-bit quarter index. It is held at zero while IDLE.
- The main FSM, shift register, and synchronizer live in i2c_controller.

## Test plan

- Write, QTR=4, addr 0x42, wdata 0x2A, target ACKs both.
  - Decoded bus shows START, bits 1000010_0, ACK, 00101010, ACK, STOP.
  - done in cycle 321; ack_err=0.
- Read addr 0x42, target drives 0xA5.
  - rdata=8'hA5; controller NACKs the 9th data bit (SDA=1 at SCL high).
  - done in cycle 321; ack_err=0.
- Address NACK, sda_in held 1.
  - No data bits on the bus; STOP follows the address ACK slot.
  - done in cycle 177; ack_err=1.
- Back-to-back: second command presented with cmd_valid held high.
  - Accepted the cycle after the first done.
  - Second START is preceded by a STOP with SCL=SDA=1 for at least 1 cycle.
- cmd_valid pulsed while busy: no effect on bus or latched data.
  - Reset asserted during ADDR: scl_out=sda_out=1 and cmd_ready=1 in the same cycle.
  - Next command after reset completes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM state, quarter-phase and R/W encodings for the I2C controller
package i2c_pkg;
  typedef enum logic [2:0] {IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP} i2c_state_t;
  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} qtr_t;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
endpackage

// File: rtl/i2c_if.sv
// i2c_if: command handshake plus SCL/SDA pins of the I2C controller
//   master: command issuer / bus peer side, slave: the controller itself
interface i2c_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_addr;
  logic       cmd_rw;
  logic [7:0] cmd_wdata;
  logic [7:0] rdata;
  logic       done;
  logic       ack_err;
  logic       busy;
  logic       scl_out;
  logic       sda_out;
  logic       sda_in;
  modport master (output cmd_valid, cmd_addr, cmd_rw, cmd_wdata, sda_in,
                  input  cmd_ready, rdata, done, ack_err, busy, scl_out, sda_out);
  modport slave  (input  cmd_valid, cmd_addr, cmd_rw, cmd_wdata, sda_in,
                  output cmd_ready, rdata, done, ack_err, busy, scl_out, sda_out);
endinterface

// File: rtl/i2c_qtr_tick.sv
// i2c_qtr_tick: QTR-cycle counter giving a quarter-end tick and the quarter index
//   en: count while high, held at zero while low; tick: last cycle of a quarter; qtr: Q0..Q3
module i2c_qtr_tick
  import i2c_pkg::*;
#(
  parameter int QTR = 25
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  output logic tick,
  output qtr_t qtr
);
  localparam int CW = $clog2(QTR);
  logic [CW-1:0] cnt_q, cnt_d;
  qtr_t qtr_q, qtr_d;
  always_comb begin
    tick  = en && (cnt_q == CW'(QTR - 1));
    cnt_d = (!en || tick) ? '0 : cnt_q + CW'(1);
    qtr_d = !en ? Q0 : tick ? qtr_t'(qtr_q + 2'd1) : qtr_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      qtr_q <= Q0;
    end else begin
      cnt_q <= cnt_d;
      qtr_q <= qtr_d;
    end
  end
  assign qtr = qtr_q;
endmodule

// File: rtl/i2c_controller.sv
// i2c_controller: single-byte I2C initiator (START, addr+R/W, ACK, data, ACK, STOP)
//   clock/reset_n: system clock, async active-low reset
//   bus (slave): cmd_* handshake in, rdata/done/ack_err/busy out, scl_out/sda_out pins, sda_in sampled line
module i2c_controller
  import i2c_pkg::*;
#(
  parameter int QTR = 25
) (
  input  logic clock,
  input  logic reset_n,
  i2c_if.slave bus
);
  i2c_state_t state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] addr_rw_q, addr_rw_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rdata_q, rdata_d;
  logic       ack_err_q, ack_err_d;
  logic       done_q, done_d;
  logic [1:0] sync_q, sync_d;
  logic       tick, qend, scl_hi, sda_s, accept, ready, scl, sda;
  qtr_t       qtr;

  i2c_qtr_tick #(.QTR(QTR)) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (state_q != IDLE),
    .tick    (tick),
    .qtr     (qtr)
  );

  assign sda_s  = sync_q[1];
  assign sync_d = {sync_q[0], bus.sda_in};
  assign qend   = tick && (qtr == Q3);
  assign scl_hi = qtr[1];
  // the done cycle still counts as busy so the next accept lands one cycle later
  assign ready  = (state_q == IDLE) && !done_q;
  assign accept = bus.cmd_valid && ready;

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    addr_rw_d = addr_rw_q;
    wdata_d   = wdata_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;
    scl       = 1'b1;
    sda       = 1'b1;
    case (state_q)
      IDLE: if (accept) begin
        state_d   = START;
        addr_rw_d = {bus.cmd_addr, bus.cmd_rw};
        wdata_d   = bus.cmd_wdata;
        ack_err_d = 1'b0;
        bit_d     = 3'd7;
      end
      START: begin
        sda = !scl_hi;
        if (qend) state_d = ADDR;
      end
      ADDR: begin
        scl = scl_hi;
        sda = addr_rw_q[bit_q];
        // bit counter wraps 0 -> 7, ready for the data byte
        if (qend) begin
          bit_d   = bit_q - 3'd1;
          state_d = (bit_q == 3'd0) ? ADDR_ACK : ADDR;
        end
      end
      ADDR_ACK: begin
        scl = scl_hi;
        if (qend) begin
          state_d   = sda_s ? STOP : DATA;
          ack_err_d = sda_s;
        end
      end
      DATA: begin
        scl = scl_hi;
        sda = (addr_rw_q[0] == I2C_RW_READ) ? 1'b1 : wdata_q[bit_q];
        if (qend) begin
          bit_d   = bit_q - 3'd1;
          rx_d    = {rx_q[6:0], sda_s};
          state_d = (bit_q == 3'd0) ? DATA_ACK : DATA;
        end
      end
      DATA_ACK: begin
        scl = scl_hi;
        // reads answer with NACK (SDA released high); writes check the target's ACK
        if (qend) begin
          state_d   = STOP;
          rdata_d   = (addr_rw_q[0] == I2C_RW_READ) ? rx_q : rdata_q;
          ack_err_d = (addr_rw_q[0] == I2C_RW_WRITE) && sda_s;
        end
      end
      STOP: begin
        scl = scl_hi;
        sda = (qtr == Q3);
        if (qend) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_q     <= 3'd7;
      addr_rw_q <= '0;
      wdata_q   <= '0;
      rx_q      <= '0;
      rdata_q   <= '0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
      sync_q    <= 2'b11;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      addr_rw_q <= addr_rw_d;
      wdata_q   <= wdata_d;
      rx_q      <= rx_d;
      rdata_q   <= rdata_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
      sync_q    <= sync_d;
    end
  end

  assign bus.cmd_ready = ready;
  assign bus.busy      = !ready;
  assign bus.done      = done_q;
  assign bus.ack_err   = ack_err_q;
  assign bus.rdata     = rdata_q;
  assign bus.scl_out   = scl;
  assign bus.sda_out   = sda;
endmodule

// File: tb/tb_i2c_controller.sv
// tb_i2c_controller: directed checks of the I2C controller with QTR=4
module tb_i2c_controller;
  import i2c_pkg::*;
  localparam int Q = 4;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic       nxt_valid = 1'b0;
  logic [6:0] nxt_addr = '0;
  logic       nxt_rw = 1'b0;
  logic [7:0] nxt_wdata = '0;
  int         pulse_at = 0;

  i2c_if bus();
  i2c_controller #(.QTR(Q)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected {scl,sda} for a bit slot (0=START, 1..8 addr, 9 ack, 10..17 data, 18 ack, then STOP)
  function automatic logic [1:0] exp_bus(input int slot, input int qq, input logic [7:0] arw,
                                         input logic [7:0] wd, input logic nack);
    logic hi;
    int   stop_slot;
    hi = (qq >= 2);
    stop_slot = nack ? 10 : 19;
    if (slot == 0) return {1'b1, qq < 2};
    if (slot == stop_slot) return {hi, qq == 3};
    if (slot <= 8) return {hi, arw[8-slot]};
    if (slot >= 10 && slot <= 17) return {hi, arw[0] ? 1'b1 : wd[17-slot]};
    return {hi, 1'b1};
  endfunction

  task automatic issue(input logic [6:0] a, input logic rw, input logic [7:0] wd);
    int w;
    w = 0;
    @(negedge clock);
    while (!bus.cmd_ready && w < 200) begin
      @(negedge clock);
      w++;
    end
    chk("ready_before_issue", bus.cmd_ready, 1);
    bus.cmd_addr  = a;
    bus.cmd_rw    = rw;
    bus.cmd_wdata = wd;
    bus.cmd_valid = 1'b1;
    @(posedge clock);
  endtask

  // call right after the accept edge; cycle 1 is the first negedge that follows
  task automatic monitor(input string tag, input logic [6:0] a, input logic rw, input logic [7:0] wd,
                         input logic ack_a, input logic [7:0] rbyte, input int exp_done,
                         input logic exp_err, input logic [7:0] exp_rd);
    logic [7:0] arw;
    int done_at, slot, qq, sub, stop_slot;
    arw = {a, rw};
    done_at = 0;
    stop_slot = ack_a ? 19 : 10;
    for (int cyc = 1; cyc <= 100 * Q && done_at == 0; cyc++) begin
      @(negedge clock);
      slot = (cyc - 1) / (4 * Q);
      qq   = ((cyc - 1) / Q) % 4;
      sub  = (cyc - 1) % Q;
      if (cyc == 1) begin
        bus.cmd_valid = nxt_valid;
        bus.cmd_addr  = nxt_addr;
        bus.cmd_rw    = nxt_rw;
        bus.cmd_wdata = nxt_wdata;
        chk({tag, "_busy"}, bus.busy, 1);
        chk({tag, "_ready_low"}, bus.cmd_ready, 0);
        chk({tag, "_ack_err_clr"}, bus.ack_err, 0);
      end
      if (pulse_at != 0 && cyc == pulse_at) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 7'h7F;
        bus.cmd_rw    = 1'b0;
        bus.cmd_wdata = 8'hFF;
      end else if (pulse_at != 0 && cyc == pulse_at + 1) bus.cmd_valid = 1'b0;
      if (sub == 0 && qq == 0)
        bus.sda_in = (slot == 9) ? !ack_a :
                     (rw && ack_a && slot >= 10 && slot <= 17) ? rbyte[17-slot] :
                     (!rw && slot == 18) ? 1'b0 : 1'b1;
      if (bus.done) done_at = cyc;
      else if (sub == Q / 2 && slot <= stop_slot)
        chk({tag, "_bus"}, {bus.scl_out, bus.sda_out}, exp_bus(slot, qq, arw, wd, !ack_a));
    end
    bus.sda_in = 1'b1;
    chk({tag, "_done_cycle"}, done_at, exp_done);
    chk({tag, "_ack_err"}, bus.ack_err, exp_err);
    chk({tag, "_rdata"}, bus.rdata, exp_rd);
    chk({tag, "_ready_in_done"}, bus.cmd_ready, 0);
    chk({tag, "_idle_bus_done"}, {bus.scl_out, bus.sda_out}, 2'b11);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_rw    = 1'b0;
    bus.cmd_wdata = '0;
    bus.sda_in    = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_scl", bus.scl_out, 1);
    chk("rst_sda", bus.sda_out, 1);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ack_err", bus.ack_err, 0);
    chk("rst_rdata", bus.rdata, 8'h00);
    reset_n = 1'b1;

    issue(7'h42, 1'b0, 8'h2A);
    monitor("wr", 7'h42, 1'b0, 8'h2A, 1'b1, 8'h00, 321, 1'b0, 8'h00);
    @(negedge clock);
    chk("wr_done_pulse", bus.done, 0);
    chk("wr_ready_after", bus.cmd_ready, 1);

    issue(7'h42, 1'b1, 8'h00);
    pulse_at = 50;
    monitor("rd", 7'h42, 1'b1, 8'h00, 1'b1, 8'hA5, 321, 1'b0, 8'hA5);
    pulse_at = 0;

    issue(7'h42, 1'b0, 8'h2A);
    monitor("nack", 7'h42, 1'b0, 8'h2A, 1'b0, 8'h00, 177, 1'b1, 8'hA5);
    @(negedge clock);
    chk("nack_err_hold", bus.ack_err, 1);
    chk("nack_ready_after", bus.cmd_ready, 1);

    issue(7'h5A, 1'b0, 8'h81);
    nxt_valid = 1'b1;
    nxt_addr  = 7'h13;
    nxt_rw    = 1'b0;
    nxt_wdata = 8'hC3;
    monitor("b2b_a", 7'h5A, 1'b0, 8'h81, 1'b1, 8'h00, 321, 1'b0, 8'hA5);
    @(negedge clock);
    chk("b2b_ready", bus.cmd_ready, 1);
    chk("b2b_idle_bus", {bus.scl_out, bus.sda_out}, 2'b11);
    @(posedge clock);
    nxt_valid = 1'b0;
    monitor("b2b_b", 7'h13, 1'b0, 8'hC3, 1'b1, 8'h00, 321, 1'b0, 8'hA5);

    issue(7'h42, 1'b0, 8'h2A);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    repeat (20) @(negedge clock);
    chk("pre_rst_busy", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_bus", {bus.scl_out, bus.sda_out}, 2'b11);
    chk("mid_rst_ready", bus.cmd_ready, 1);
    chk("mid_rst_busy", bus.busy, 0);
    @(negedge clock);
    reset_n = 1'b1;
    issue(7'h42, 1'b0, 8'h2A);
    monitor("post_rst", 7'h42, 1'b0, 8'h2A, 1'b1, 8'h00, 321, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
